// File: rtl/core_harness_ctrl.sv
// Program-load / run / dump sequencer for the core test harness.
// Define HARNESS_HDR_EN to prefix the dump with the 4-byte cycle count.
module core_harness_ctrl #(
  parameter int          ADDR_BITS  = 10,
  parameter int          ROM_BYTES  = 1024,
  parameter int          RAM_BYTES  = 1024,
  parameter int unsigned RUN_CYCLES = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic                 rom_we,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic [7:0]           rom_wdata,
  output logic                 core_rst,
  input  logic                 halt,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [7:0]           ram_rdata,
  output logic                 dump_valid,
  output logic [7:0]           dump_data,
  output logic                 dump_last,
  input  logic                 dump_ready,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          cycles
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] ROM_LAST = CW'(ROM_BYTES - 1);
  localparam logic [CW-1:0] RAM_LAST = CW'(RAM_BYTES - 1);
  localparam logic [31:0]   RUN_MAX  = 32'(RUN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_cycles;
  logic [7:0]      r_dump_data;

  logic            w_start;
  logic            w_ld_hs;
  logic            w_ld_last;
  logic            w_tmo;
  logic            w_dump_hs;
  logic            w_hdr;
  logic            w_last;
  logic [7:0]      w_cap_byte;

`ifdef HARNESS_HDR_EN
  logic [2:0]      r_hdr_idx;

  // Header phase lasts while the index has not yet reached 4.
  assign w_hdr      = ~r_hdr_idx[2];
  assign w_cap_byte = w_hdr ? r_cycles[{r_hdr_idx[1:0], 3'b000} +: 8]
                            : ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hdr_idx <= 3'd0;
    end else if (w_start) begin
      r_hdr_idx <= 3'd0;
    end else if (w_dump_hs && w_hdr) begin
      r_hdr_idx <= r_hdr_idx + 3'd1;
    end
  end
`else
  assign w_hdr      = 1'b0;
  assign w_cap_byte = ram_rdata;
`endif

  assign w_start   = start &&
                     (r_state == S_IDLE || r_state == S_DONE);
  assign w_ld_hs   = (r_state == S_LOAD) && ld_valid;
  assign w_ld_last = w_ld_hs && (r_cnt == ROM_LAST);
  assign w_tmo     = (r_state == S_RUN) && !halt &&
                     (r_cycles + 32'd1 == RUN_MAX);
  assign w_dump_hs = (r_state == S_DUMP_OUT) && dump_ready;
  assign w_last    = !w_hdr && (r_cnt == RAM_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_ld_last) w_next = S_RUN;
      end
      S_RUN: begin
        if (halt || w_tmo) w_next = S_DUMP_RD;
      end
      S_DUMP_RD:  w_next = S_DUMP_CAP;
      S_DUMP_CAP: w_next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (dump_ready) w_next = w_last ? S_DONE : S_DUMP_RD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_cycles    <= 32'd0;
      r_dump_data <= 8'd0;
    end else begin
      if (w_start) begin
        r_cnt    <= '0;
        r_cycles <= 32'd0;
      end
      if (w_ld_hs) begin
        r_cnt <= w_ld_last ? '0 : r_cnt + 1'b1;
      end
      if (r_state == S_RUN && !halt) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (r_state == S_DUMP_CAP) begin
        r_dump_data <= w_cap_byte;
      end
      if (w_dump_hs && !w_last && !w_hdr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ld_ready   = (r_state == S_LOAD);
  assign rom_we     = w_ld_hs;
  assign rom_addr   = w_ld_hs ? r_cnt[ADDR_BITS-1:0] : '0;
  assign rom_wdata  = w_ld_hs ? ld_data : 8'd0;
  assign core_rst   = (r_state != S_RUN);
  assign ram_rd_en  = (r_state == S_DUMP_RD) && !w_hdr;
  assign ram_addr   = ram_rd_en ? r_cnt[ADDR_BITS-1:0] : '0;
  assign dump_valid = (r_state == S_DUMP_OUT);
  assign dump_data  = r_dump_data;
  assign dump_last  = dump_valid && w_last;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_core_harness_ctrl.sv
// Directed bench for core_harness_ctrl: load, timeout/halt runs,
// dump with steady and random backpressure, mid-load reset.
module tb_core_harness_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_wdata;
  logic          core_rst;
  logic          halt;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata = 8'd0;
  logic          dump_valid;
  logic [7:0]    dump_data;
  logic          dump_last;
  logic          dump_ready;
  logic          busy;
  logic          done;
  logic [31:0]   cycles;

  int n_chk = 0;
  int n_err = 0;

  core_harness_ctrl #(
    .ADDR_BITS (AW),
    .ROM_BYTES (8),
    .RAM_BYTES (8),
    .RUN_CYCLES(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .core_rst  (core_rst),
    .halt      (halt),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .dump_valid(dump_valid),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .dump_ready(dump_ready),
    .busy      (busy),
    .done      (done),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  // RAM preloaded with 0xA0 + address, one-cycle read latency
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= {5'b10100, ram_addr[2:0]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_prog(input logic [7:0] base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("ld_corerst", {31'd0, core_rst}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      #1;
      chk("rom_we", {31'd0, rom_we}, 32'd1);
      chk("rom_addr", {22'd0, rom_addr}, 32'(i));
      chk("rom_wdata", {24'd0, rom_wdata}, 32'(base + 8'(i)));
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    chk("run_entry", {31'd0, core_rst}, 32'd0);
  endtask

  task automatic run_to_timeout();
    int n;
    n = 0;
    while (core_rst == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("run_len", 32'(n), 32'd20);
    chk("cyc_tmo", cycles, 32'd20);
    chk("exit_nvalid", {31'd0, dump_valid}, 32'd0);
`ifdef HARNESS_HDR_EN
    chk("exit_rd_en", {31'd0, ram_rd_en}, 32'd0);
`else
    chk("exit_rd_en", {31'd0, ram_rd_en}, 32'd1);
`endif
  endtask

  task automatic run_dump(input bit rnd, input logic [31:0] cyc);
    logic [7:0] exp [0:11];
    int         nexp;
    int         idx;
    int         guard;
    int         first_v;
    bit         hold;
    logic [7:0] prev;
    nexp = 0;
`ifdef HARNESS_HDR_EN
    for (int b = 0; b < 4; b++) begin
      exp[nexp] = cyc[b*8 +: 8];
      nexp++;
    end
`endif
    for (int b = 0; b < 8; b++) begin
      exp[nexp] = 8'hA0 + 8'(b);
      nexp++;
    end
    idx = 0;
    guard = 0;
    first_v = -1;
    hold = 1'b0;
    prev = 8'd0;
    while (idx < nexp && guard < 500) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (dump_valid) begin
        if (first_v < 0) first_v = guard;
        if (hold) chk("hold", {24'd0, dump_data}, {24'd0, prev});
        if (dump_ready) begin
          chk("dbyte", {24'd0, dump_data}, {24'd0, exp[idx]});
          chk("dlast", {31'd0, dump_last},
              (idx == nexp - 1) ? 32'd1 : 32'd0);
          idx++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          prev = dump_data;
        end
      end
      @(negedge clk);
      guard++;
    end
    dump_ready = 1'b0;
    #1;
    chk("first_valid", 32'(first_v), 32'd2);
    chk("dump_cnt", 32'(idx), 32'(nexp));
    chk("done", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_cyc", cycles, cyc);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 8'd0;
    halt       = 1'b0;
    dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_corerst", {31'd0, core_rst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_ldready", {31'd0, ld_ready}, 32'd0);
    chk("rst_dvalid", {31'd0, dump_valid}, 32'd0);
    chk("rst_ddata", {24'd0, dump_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // stray load byte in IDLE is ignored
    ld_valid = 1'b1;
    #1;
    chk("idle_rom_we", {31'd0, rom_we}, 32'd0);
    ld_valid = 1'b0;

    load_prog(8'h10);
    run_to_timeout();
    run_dump(1'b0, 32'd20);

    // halt on the 5th RUN clock
    load_prog(8'h20);
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    #1;
    chk("halt_corerst", {31'd0, core_rst}, 32'd1);
    chk("halt_cyc", cycles, 32'd4);
    run_dump(1'b1, 32'd4);

    // reset after 3 load bytes
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h40 + 8'(i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_corerst", {31'd0, core_rst}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ldready", {31'd0, ld_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load_prog(8'h30);
    run_to_timeout();
    run_dump(1'b1, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_harness_ctrl.md
# core_harness_ctrl

Parametrised program-load / run / dump controller for the RISC-V core, replacing fixed-time bench sequencing with synthesizable hardware. It streams a program image byte-by-byte into instruction ROM with the core held in reset. It then releases the core for a bounded cycle budget, or until halt, and re-freezes it. Finally it streams the data RAM contents out on a handshaked byte port. It sits between an external host link (UART/JTAG bridge or bench) and the core's ROM write port, RAM read port and reset.

## Interface
Parameters:
- ADDR_BITS, 10, address width of ROM/RAM byte ports
- ROM_BYTES, 1024, bytes loaded per program; 1..2**ADDR_BITS
- RAM_BYTES, 1024, bytes dumped; 1..2**ADDR_BITS
- RUN_CYCLES, 2500, maximum core run length in clocks; ≥1, < 2**32

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin load/run/dump sequence; sampled in IDLE and DONE only
- ld_valid  in  1  load byte valid
- ld_data  in  8  load byte
- ld_ready  out  1  controller accepts load byte
- rom_we  out  1  ROM byte write strobe
- rom_addr  out  ADDR_BITS  ROM byte address
- rom_wdata  out  8  ROM write byte
- core_rst  out  1  core reset, active-high
- halt  in  1  core halt request; ends RUN early
- ram_rd_en  out  1  RAM byte read strobe
- ram_addr  out  ADDR_BITS  RAM byte address
- ram_rdata  in  8  RAM read byte; valid the cycle after ram_rd_en
- dump_valid  out  1  dump byte valid
- dump_data  out  8  dump byte
- dump_last  out  1  final dump byte flag, qualified by dump_valid
- dump_ready  in  1  downstream accepts dump byte
- busy  out  1  high in LOAD, RUN and all DUMP states
- done  out  1  high in DONE
- cycles  out  32  core cycles executed in last RUN

## Operation
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- IDLE/DONE + start=1 → LOAD. The byte counter and cycles are cleared to 0. start is ignored in all other states.
- LOAD: ld_ready=1. Each cycle with ld_valid=1 writes the byte: rom_we=1, rom_addr=counter, rom_wdata=ld_data (combinational from the handshake), and the counter increments. On byte ROM_BYTES-1 accepted → RUN with the counter cleared. ld_valid outside LOAD is ignored.
- RUN: core_rst=0. Each edge with halt=0 increments cycles. Exit to DUMP_RD occurs when halt=1 (cycles not incremented) or when cycles+1 == RUN_CYCLES (incremented). halt and timeout in the same cycle: halt wins, with no increment.
- DUMP_RD: ram_rd_en=1, ram_addr=counter → DUMP_CAP.
- DUMP_CAP: register ram_rdata into dump_data → DUMP_OUT.
- DUMP_OUT: dump_valid=1, with dump_data held stable until dump_ready=1. dump_last=1 when counter==RAM_BYTES-1. On handshake: if last → DONE, else counter+1 → DUMP_RD.
- DONE: done=1. cycles and dump_data hold their values.
- Address wrap: counters are ADDR_BITS+1 wide internally. The exit comparison is against the parameter, never against overflow.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, core_rst=1, cycles=0, dump_data=0, counter=0. All other outputs are 0.
- core_rst=1 in every state except RUN. It deasserts on the edge entering RUN and reasserts on the edge leaving RUN, so the core runs exactly cycles clocks.
- Load throughput: one byte per clock with ld_valid held high. Last byte write → RUN on the next edge.
- Dump throughput: 3 clocks per byte with dump_ready held high. The first dump_valid occurs 2 clocks after RUN exit.
- Reset mid-sequence aborts immediately. Partially loaded ROM contents are left as-is. The core is held in reset.

## Configuration
- HARNESS_HDR_EN defined: the dump stream is prefixed with 4 header bytes, cycles[7:0], [15:8], [23:16], [31:24]. Each is presented in DUMP_OUT without a RAM read. dump_last is never set on header bytes.
- Undefined: the dump begins directly with RAM byte 0. The total dump length is RAM_BYTES.

## Test plan
Benches use ROM_BYTES=8, RAM_BYTES=8, RUN_CYCLES=20.
- Reset check: hold rst=0 → core_rst=1, busy=0, done=0, cycles=0, ld_ready=0. Pulse start, then stream 8 bytes 0x10..0x17 back-to-back → rom_we on 8 consecutive cycles, addr 0..7 with matching data, RUN entered next edge.
- halt never asserted → core_rst low for exactly 20 clocks, cycles=20. Then RAM preloaded 0xA0..0xA7 is dumped in order, dump_last only on 0xA7, then done=1.
- halt asserted on the 5th RUN clock → cycles=4, core_rst high on the next edge, dump follows.
- dump_ready toggled 0/1 randomly → dump_data stable while valid&&!ready, no byte lost or duplicated, 8 handshakes total.
- rst=0 mid-LOAD after 3 bytes → IDLE immediately, core_rst=1. A new start reloads from address 0.
- HARNESS_HDR_EN with timeout → first four bytes 0x14,0x00,0x00,0x00, then 8 RAM bytes, dump_last on the 12th.
